// File: rtl/mem_wishbone_bridge_pkg.sv
// Shared types and Wishbone B4 cycle-tag constants
// for the memory-request to Wishbone bridge.
package mem_wishbone_bridge_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } bridge_state_t;

endpackage

// File: rtl/mem_wishbone_bridge.sv
// Core memory request port to Wishbone B4 master:
// single writes and incrementing read bursts.
module mem_wishbone_bridge
    import mem_wishbone_bridge_pkg::*;
#(
    parameter bit BURST_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic [29:0] addr,
    input  logic [4:0]  rlen,
    input  logic        rnw,
    input  logic        rmw,
    input  logic [3:0]  wbe,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        inv,
    output logic [29:0] inv_addr,
    output logic        write_outstanding,
    output logic [29:0] wb_adr,
    output logic [31:0] wb_dat_w,
    output logic [3:0]  wb_sel,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [2:0]  wb_cti,
    output logic [1:0]  wb_bte,
    input  logic [31:0] wb_dat_r,
    input  logic        wb_ack,
    input  logic        wb_err
);

    bridge_state_t state;
    logic [29:0]   addr_q;
    logic [4:0]    rlen_q;
    logic [4:0]    beat;
    logic [3:0]    wbe_q;
    logic [31:0]   wdata_q;
    logic          beat_done;
    logic          last_beat;
    logic          unused;

    // rmw gets no special treatment; it is a plain read or write
    assign unused    = rmw;
    assign beat_done = wb_ack | wb_err;
    assign last_beat = (beat == rlen_q);
    assign ack       = (state == IDLE) & request & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            rlen_q  <= '0;
            beat    <= '0;
            wbe_q   <= '0;
            wdata_q <= '0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        addr_q  <= addr;
                        rlen_q  <= rlen;
                        wbe_q   <= wbe;
                        wdata_q <= wdata;
                        beat    <= '0;
                        state   <= rnw ? READ : WRITE;
                    end
                end
                READ: begin
                    // errored beats still return data
                    if (beat_done) begin
                        rvalid <= 1'b1;
                        rdata  <= wb_dat_r;
                        beat   <= beat + 5'd1;
                        if (last_beat) state <= IDLE;
                    end
                end
                WRITE: begin
                    if (beat_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wb_cyc            = (state != IDLE);
        wb_stb            = (state != IDLE);
        wb_we             = (state == WRITE);
        write_outstanding = (state == WRITE);
        wb_adr            = addr_q + 30'(beat);
        wb_dat_w          = wdata_q;
        wb_bte            = BTE_LINEAR;
        wb_sel            = '0;
        wb_cti            = CTI_CLASSIC;
        if (state == WRITE) wb_sel = wbe_q;
        if (state == READ) begin
            wb_sel = 4'hF;
            if (BURST_EN && rlen_q != 5'd0)
                wb_cti = last_beat ? CTI_EOB : CTI_INCR;
        end
    end

    assign inv      = 1'b0;
    assign inv_addr = '0;

endmodule

// File: tb/tb_mem_wishbone_bridge.sv
// Directed bench for mem_wishbone_bridge with a
// scoreboarded Wishbone slave model.
module tb_mem_wishbone_bridge;

    logic        clk;
    logic        rst;
    logic        request;
    logic [29:0] addr;
    logic [4:0]  rlen;
    logic        rnw;
    logic        rmw;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_err;

    logic        ack, rvalid, inv, wo;
    logic [31:0] rdata, wb_dat_w;
    logic [29:0] inv_addr, wb_adr;
    logic [3:0]  wb_sel;
    logic        wb_cyc, wb_stb, wb_we;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;

    logic        ack0, rvalid0, inv0, wo0;
    logic [31:0] rdata0, datw0;
    logic [29:0] inv_addr0, adr0;
    logic [3:0]  sel0;
    logic        cyc0, stb0, we0;
    logic [2:0]  cti0;
    logic [1:0]  bte0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_rv  = 0;
    int          slv_wait = 0;
    int          err_beat = -1;
    logic [31:0] exp_q[$];

    mem_wishbone_bridge #(.BURST_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .request(request), .addr(addr),
        .rlen(rlen), .rnw(rnw), .rmw(rmw), .wbe(wbe), .wdata(wdata),
        .ack(ack), .rvalid(rvalid), .rdata(rdata), .inv(inv),
        .inv_addr(inv_addr), .write_outstanding(wo), .wb_adr(wb_adr),
        .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_cyc(wb_cyc),
        .wb_stb(wb_stb), .wb_we(wb_we), .wb_cti(wb_cti),
        .wb_bte(wb_bte), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack),
        .wb_err(wb_err)
    );

    mem_wishbone_bridge #(.BURST_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .request(request), .addr(addr),
        .rlen(rlen), .rnw(rnw), .rmw(rmw), .wbe(wbe), .wdata(wdata),
        .ack(ack0), .rvalid(rvalid0), .rdata(rdata0), .inv(inv0),
        .inv_addr(inv_addr0), .write_outstanding(wo0), .wb_adr(adr0),
        .wb_dat_w(datw0), .wb_sel(sel0), .wb_cyc(cyc0),
        .wb_stb(stb0), .wb_we(we0), .wb_cti(cti0),
        .wb_bte(bte0), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack),
        .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [29:0] a);
        return {a, 2'b00} ^ 32'h0000_0400 ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #4;
    endtask

    task automatic req(input logic [29:0] a, input logic [4:0] l,
                       input logic rd, input logic [3:0] be,
                       input logic [31:0] wd);
        request = 1'b1;
        addr    = a;
        rlen    = l;
        rnw     = rd;
        wbe     = be;
        wdata   = wd;
    endtask

    // slave: slv_wait wait states per beat, optional error on one beat
    initial begin : slave
        int wcnt;
        int bidx;
        wcnt = 0;
        bidx = 0;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        wb_dat_r = '0;
        forever begin
            @(posedge clk);
            #1;
            wb_ack = 1'b0;
            wb_err = 1'b0;
            if (!wb_cyc) begin
                wcnt = 0;
                bidx = 0;
            end else if (wcnt < slv_wait) begin
                wcnt++;
            end else begin
                wcnt = 0;
                if (bidx == err_beat) wb_err = 1'b1;
                else wb_ack = 1'b1;
                bidx++;
                if (!wb_we) begin
                    wb_dat_r = data_of(wb_adr);
                    exp_q.push_back(wb_dat_r);
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rvalid === 1'b1) begin
                n_rv++;
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("rdata", rdata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst = 1'b1;
        request = 1'b0;
        addr = '0;
        rlen = '0;
        rnw = 1'b0;
        rmw = 1'b0;
        wbe = '0;
        wdata = '0;
        repeat (2) nxt();
        request = 1'b1;
        smp();
        chk("rst_ack", ack, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_cyc", wb_cyc, 0);
        chk("rst_stb", wb_stb, 0);
        chk("rst_we", wb_we, 0);
        chk("rst_adr", wb_adr, 0);
        chk("rst_sel", wb_sel, 0);
        chk("rst_datw", wb_dat_w, 0);
        chk("rst_cti", wb_cti, 0);
        chk("rst_wo", wo, 0);
        chk("bte", wb_bte, 0);
        chk("inv", inv, 0);
        chk("inv_addr", inv_addr, 0);
        nxt();
        rst = 1'b0;
        request = 1'b0;
        nxt();

        // single read, one wait state
        slv_wait = 1;
        nxt();
        req(30'h100, 5'd0, 1'b1, 4'h0, 32'h0);
        smp();
        chk("t1_ack", ack, 1);
        chk("t1_cyc0", wb_cyc, 0);
        nxt();
        request = 1'b0;
        smp();
        chk("t1_ack_pulse", ack, 0);
        chk("t1_cyc", wb_cyc, 1);
        chk("t1_stb", wb_stb, 1);
        chk("t1_we", wb_we, 0);
        chk("t1_adr", wb_adr, 30'h100);
        chk("t1_cti", wb_cti, 3'b000);
        chk("t1_rv_c1", rvalid, 0);
        nxt();
        smp();
        chk("t1_cyc_wait", wb_cyc, 1);
        chk("t1_rv_c2", rvalid, 0);
        nxt();
        smp();
        chk("t1_rv_c3", rvalid, 1);
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        chk("t1_cyc_end", wb_cyc, 0);
        nxt();
        smp();
        chk("t1_rv_c4", rvalid, 0);

        // 4-word burst, zero wait
        slv_wait = 0;
        nxt();
        req(30'h200, 5'd3, 1'b1, 4'h0, 32'h0);
        smp();
        chk("t2_ack", ack, 1);
        for (int c = 1; c <= 6; c++) begin
            nxt();
            request = 1'b0;
            smp();
            chk($sformatf("t2_rv_c%0d", c), rvalid,
                32'((c >= 2) && (c <= 5)));
            if (c <= 4) begin
                chk($sformatf("t2_adr_c%0d", c), wb_adr,
                    32'h200 + 32'(c - 1));
                chk($sformatf("t2_cti_c%0d", c), wb_cti,
                    (c == 4) ? 32'd7 : 32'd2);
            end else begin
                chk($sformatf("t2_cyc_c%0d", c), wb_cyc, 0);
            end
        end

        // write, with a read request held behind it
        nxt();
        req(30'h40, 5'd0, 1'b0, 4'b0101, 32'h1234_5678);
        smp();
        chk("t3_ack", ack, 1);
        nxt();
        req(30'h500, 5'd0, 1'b1, 4'h0, 32'h0);
        smp();
        chk("t3_busy_ack", ack, 0);
        chk("t3_cyc", wb_cyc, 1);
        chk("t3_we", wb_we, 1);
        chk("t3_sel", wb_sel, 4'b0101);
        chk("t3_datw", wb_dat_w, 32'h1234_5678);
        chk("t3_adr", wb_adr, 30'h40);
        chk("t3_cti", wb_cti, 0);
        chk("t3_wo", wo, 1);
        nxt();
        smp();
        chk("t3_wo_fall", wo, 0);
        chk("t3_next_ack", ack, 1);
        chk("t3_rv", rvalid, 0);
        nxt();
        request = 1'b0;
        smp();
        chk("t3_rd_adr", wb_adr, 30'h500);
        chk("t3_rd_we", wb_we, 0);
        nxt();
        smp();
        chk("t3_rd_rv", rvalid, 1);

        // address wrap
        nxt();
        req(30'h3FFF_FFFF, 5'd1, 1'b1, 4'h0, 32'h0);
        smp();
        chk("t4_ack", ack, 1);
        nxt();
        request = 1'b0;
        smp();
        chk("t4_adr0", wb_adr, 30'h3FFF_FFFF);
        chk("t4_cti0", wb_cti, 3'b010);
        nxt();
        smp();
        chk("t4_adr1", wb_adr, 30'h0);
        chk("t4_cti1", wb_cti, 3'b111);
        nxt();
        smp();
        chk("t4_rv", rvalid, 1);
        chk("t4_cyc", wb_cyc, 0);

        // error on beat 2 of 4; BURST_EN=0 copy tags classic
        err_beat = 1;
        nxt();
        req(30'h600, 5'd3, 1'b1, 4'h0, 32'h0);
        smp();
        for (int c = 1; c <= 5; c++) begin
            nxt();
            request = 1'b0;
            smp();
            if (c <= 4) begin
                chk($sformatf("t5_cti_c%0d", c), wb_cti,
                    (c == 4) ? 32'd7 : 32'd2);
                chk($sformatf("t5_cti0_c%0d", c), cti0, 0);
                chk($sformatf("t5_adr_c%0d", c), wb_adr,
                    32'h600 + 32'(c - 1));
            end
            if (c >= 2) chk($sformatf("t5_rv_c%0d", c), rvalid, 1);
        end
        err_beat = -1;

        // reset in the middle of an 8-word burst
        nxt();
        req(30'h700, 5'd7, 1'b1, 4'h0, 32'h0);
        smp();
        chk("t6_ack", ack, 1);
        nxt();
        request = 1'b0;
        smp();
        nxt();
        smp();
        chk("t6_rv_c2", rvalid, 1);
        nxt();
        rst = 1'b1;
        smp();
        chk("t6_rv_c3", rvalid, 1);
        chk("t6_cyc_c3", wb_cyc, 1);
        nxt();
        rst = 1'b0;
        exp_q.delete();
        req(30'h800, 5'd0, 1'b1, 4'h0, 32'h0);
        smp();
        chk("t6_cyc_drop", wb_cyc, 0);
        chk("t6_rv_c4", rvalid, 0);
        chk("t6_new_ack", ack, 1);
        nxt();
        request = 1'b0;
        smp();
        chk("t6_rv_c5", rvalid, 0);
        chk("t6_new_adr", wb_adr, 30'h800);
        nxt();
        smp();
        chk("t6_new_rv", rvalid, 1);
        nxt();
        smp();
        chk("t6_rv_end", rvalid, 0);

        nxt();
        chk("sb_empty", exp_q.size(), 0);
        chk("rv_count", n_rv, 15);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
